// File: rtl/bus_sched_if.sv
// Signal bundle between the CPU/DMA requesters and the bus cycle scheduler.
// The scheduler takes the slave modport; the requester side takes master.
interface bus_sched_if;
   logic        cpu_req;
   logic [15:0] cpu_addr;
   logic        cpu_rw;
   logic        dma_req;
   logic [15:0] dma_addr;
   logic        dma_rw;
   logic        bus_en;
   logic [15:0] bus_addr;
   logic        bus_rw;
   logic        cpu_ack;
   logic        dma_ack;
   logic        owner;

   modport slave (
      input  cpu_req, cpu_addr, cpu_rw,
      input  dma_req, dma_addr, dma_rw,
      output bus_en, bus_addr, bus_rw,
      output cpu_ack, dma_ack, owner
   );

   modport master (
      output cpu_req, cpu_addr, cpu_rw,
      output dma_req, dma_addr, dma_rw,
      input  bus_en, bus_addr, bus_rw,
      input  cpu_ack, dma_ack, owner
   );
endinterface

// File: rtl/bus_sched.sv
// Bus cycle scheduler: round-robin CPU/DMA arbitration, per-region wait
// states from addr[15:12], and a one-cycle acknowledge to the winner.
module bus_sched #(
   parameter int RAM_WAIT = 0,
   parameter int EXP_WAIT = 1,
   parameter int IO_WAIT  = 2,
   parameter int ROM_WAIT = 1
) (
   input  logic         clk,
   input  logic         rst,
   bus_sched_if.slave   bif
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        bus_en_q, bus_en_d;
   logic [15:0] bus_addr_q, bus_addr_d;
   logic        bus_rw_q, bus_rw_d;
   logic        cpu_ack_q, cpu_ack_d;
   logic        dma_ack_q, dma_ack_d;
   logic        owner_q, owner_d;

   logic        grant_dma;
   logic [15:0] win_addr;
   logic [3:0]  win_wait;

   function automatic logic [3:0] region_wait(input logic [3:0] nib);
      logic [3:0] w;
      case (nib)
         4'h0, 4'h1, 4'h2, 4'h3,
         4'h4, 4'h5, 4'h6, 4'h7: w = 4'(RAM_WAIT);
         4'hA, 4'hB, 4'hC:       w = 4'(EXP_WAIT);
         4'hD:                   w = 4'(IO_WAIT);
         4'hE, 4'hF:             w = 4'(ROM_WAIT);
         default:                w = 4'd0;
      endcase
      return w;
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bus_en_d   = bus_en_q;
      bus_addr_d = bus_addr_q;
      bus_rw_d   = bus_rw_q;
      owner_d    = owner_q;
      cpu_ack_d  = 1'b0;
      dma_ack_d  = 1'b0;
      // On a tie the requester that did not hold the bus last wins.
      grant_dma  = bif.dma_req & (~bif.cpu_req | ~owner_q);
      win_addr   = grant_dma ? bif.dma_addr : bif.cpu_addr;
      win_wait   = region_wait(win_addr[15:12]);

      case (state_q)
         IDLE: begin
            bus_en_d = 1'b0;
            if (bif.cpu_req || bif.dma_req) begin
               state_d    = ACCESS;
               bus_en_d   = 1'b1;
               bus_addr_d = win_addr;
               bus_rw_d   = grant_dma ? bif.dma_rw : bif.cpu_rw;
               owner_d    = grant_dma;
               cnt_d      = win_wait;
               if (win_wait == 4'd0) begin
                  cpu_ack_d = ~grant_dma;
                  dma_ack_d = grant_dma;
               end
            end
         end
         ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
               // Ack is registered, so raise it as we enter the final cycle.
               if (cnt_q == 4'd1) begin
                  cpu_ack_d = ~owner_q;
                  dma_ack_d = owner_q;
               end
            end else begin
               state_d  = IDLE;
               bus_en_d = 1'b0;
            end
         end
         default: begin
            state_d  = IDLE;
            bus_en_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         bus_en_q   <= 1'b0;
         bus_addr_q <= 16'h0000;
         bus_rw_q   <= 1'b1;
         cpu_ack_q  <= 1'b0;
         dma_ack_q  <= 1'b0;
         owner_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bus_en_q   <= bus_en_d;
         bus_addr_q <= bus_addr_d;
         bus_rw_q   <= bus_rw_d;
         cpu_ack_q  <= cpu_ack_d;
         dma_ack_q  <= dma_ack_d;
         owner_q    <= owner_d;
      end
   end

   assign bif.bus_en   = bus_en_q;
   assign bif.bus_addr = bus_addr_q;
   assign bif.bus_rw   = bus_rw_q;
   assign bif.cpu_ack  = cpu_ack_q;
   assign bif.dma_ack  = dma_ack_q;
   assign bif.owner    = owner_q;

endmodule

// File: tb/tb_bus_sched.sv
// Directed bench for bus_sched: cycle-by-cycle vector table plus hand-written
// reset sequences, with an always-on ack/bus_en consistency monitor.
module tb_bus_sched;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   bus_sched_if bif ();

   bus_sched #(
      .RAM_WAIT (0),
      .EXP_WAIT (1),
      .IO_WAIT  (2),
      .ROM_WAIT (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bif (bif.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        cr;
      logic [15:0] ca;
      logic        cw;
      logic        dr;
      logic [15:0] da;
      logic        dw;
      logic [20:0] exp;
   } vec_t;

   vec_t vecs[$];

   // Packed outputs: {bus_en, bus_addr, bus_rw, cpu_ack, dma_ack, owner}
   function automatic logic [20:0] ex(input logic en, input logic [15:0] a,
                                      input logic rw, input logic ca,
                                      input logic da, input logic own);
      return {en, a, rw, ca, da, own};
   endfunction

   function automatic vec_t mk(input logic cr, input logic [15:0] ca, input logic cw,
                               input logic dr, input logic [15:0] da, input logic dw,
                               input logic [20:0] e);
      vec_t v;
      v.cr = cr; v.ca = ca; v.cw = cw;
      v.dr = dr; v.da = da; v.dw = dw;
      v.exp = e;
      return v;
   endfunction

   task automatic chk(input string name, input logic [20:0] e);
      logic [20:0] act;
      act = {bif.bus_en, bif.bus_addr, bif.bus_rw, bif.cpu_ack, bif.dma_ack, bif.owner};
      checks++;
      if (act !== e) begin
         failures++;
         $display("FAIL %s: got en=%b addr=%h rw=%b cack=%b dack=%b own=%b, want en=%b addr=%h rw=%b cack=%b dack=%b own=%b",
                  name, act[20], act[19:4], act[3], act[2], act[1], act[0],
                  e[20], e[19:4], e[3], e[2], e[1], e[0]);
      end
   endtask

   task automatic drive(input logic cr, input logic [15:0] ca, input logic cw,
                        input logic dr, input logic [15:0] da, input logic dw);
      bif.cpu_req = cr; bif.cpu_addr = ca; bif.cpu_rw = cw;
      bif.dma_req = dr; bif.dma_addr = da; bif.dma_rw = dw;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Acks must be exclusive and only appear while the bus is enabled.
   always @(negedge clk) begin
      checks++;
      if ((bif.cpu_ack && bif.dma_ack) || ((bif.cpu_ack || bif.dma_ack) && !bif.bus_en)) begin
         failures++;
         $display("FAIL ack_invariant: cack=%b dack=%b en=%b, want exclusive acks with en=1",
                  bif.cpu_ack, bif.dma_ack, bif.bus_en);
      end
   end

   initial begin
      // RAM read, zero waits
      vecs.push_back(mk(1, 16'h1234, 1, 0, 16'h0000, 1, ex(1, 16'h1234, 1, 1, 0, 0)));
      vecs.push_back(mk(0, 16'h1234, 1, 0, 16'h0000, 1, ex(0, 16'h1234, 1, 0, 0, 0)));
      vecs.push_back(mk(0, 16'h1234, 1, 0, 16'h0000, 1, ex(0, 16'h1234, 1, 0, 0, 0)));
      // PIA write by DMA, two waits
      vecs.push_back(mk(0, 16'h0000, 1, 1, 16'hD012, 0, ex(1, 16'hD012, 0, 0, 0, 1)));
      vecs.push_back(mk(0, 16'h0000, 1, 1, 16'hD012, 0, ex(1, 16'hD012, 0, 0, 0, 1)));
      vecs.push_back(mk(0, 16'h0000, 1, 1, 16'hD012, 0, ex(1, 16'hD012, 0, 0, 1, 1)));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 16'hD012, 0, ex(0, 16'hD012, 0, 0, 0, 1)));
      // Round-robin on ROM, both requests held
      for (int g = 0; g < 4; g++) begin
         logic d;
         d = (g % 2 == 1);
         vecs.push_back(mk(1, 16'hE000, 1, 1, 16'hE000, 1, ex(1, 16'hE000, 1, 0, 0, d)));
         vecs.push_back(mk(1, 16'hE000, 1, 1, 16'hE000, 1, ex(1, 16'hE000, 1, ~d, d, d)));
         if (g < 3)
            vecs.push_back(mk(1, 16'hE000, 1, 1, 16'hE000, 1, ex(0, 16'hE000, 1, 0, 0, d)));
         else
            vecs.push_back(mk(0, 16'hE000, 1, 0, 16'hE000, 1, ex(0, 16'hE000, 1, 0, 0, d)));
      end
      // Expansion access with request dropped mid-access
      vecs.push_back(mk(1, 16'hA000, 1, 0, 16'h0000, 1, ex(1, 16'hA000, 1, 0, 0, 0)));
      vecs.push_back(mk(0, 16'hA000, 1, 0, 16'h0000, 1, ex(1, 16'hA000, 1, 1, 0, 0)));
      vecs.push_back(mk(0, 16'hA000, 1, 0, 16'h0000, 1, ex(0, 16'hA000, 1, 0, 0, 0)));
      // Unmapped region forces zero waits
      vecs.push_back(mk(0, 16'h0000, 1, 1, 16'h8000, 1, ex(1, 16'h8000, 1, 0, 1, 1)));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h8000, 1, ex(0, 16'h8000, 1, 0, 0, 1)));
      // Region edges: 0x7FFF is RAM, 0xCFFF is expansion
      vecs.push_back(mk(1, 16'h7FFF, 0, 0, 16'h0000, 1, ex(1, 16'h7FFF, 0, 1, 0, 0)));
      vecs.push_back(mk(0, 16'h7FFF, 0, 0, 16'h0000, 1, ex(0, 16'h7FFF, 0, 0, 0, 0)));
      vecs.push_back(mk(1, 16'hCFFF, 1, 0, 16'h0000, 1, ex(1, 16'hCFFF, 1, 0, 0, 0)));
      vecs.push_back(mk(0, 16'hCFFF, 1, 0, 16'h0000, 1, ex(1, 16'hCFFF, 1, 1, 0, 0)));
      vecs.push_back(mk(0, 16'hCFFF, 1, 0, 16'h0000, 1, ex(0, 16'hCFFF, 1, 0, 0, 0)));
      // Tie after a CPU grant goes to DMA; CPU held through the ack is re-granted
      vecs.push_back(mk(1, 16'h0100, 1, 1, 16'h0200, 0, ex(1, 16'h0200, 0, 0, 1, 1)));
      vecs.push_back(mk(1, 16'h0100, 1, 0, 16'h0200, 0, ex(0, 16'h0200, 0, 0, 0, 1)));
      vecs.push_back(mk(1, 16'h0100, 1, 0, 16'h0200, 0, ex(1, 16'h0100, 1, 1, 0, 0)));
      vecs.push_back(mk(0, 16'h0100, 1, 0, 16'h0200, 0, ex(0, 16'h0100, 1, 0, 0, 0)));

      // Reset held with both requests asserted
      drive(1, 16'h1234, 1, 1, 16'hD012, 0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("reset_hold", ex(0, 16'h0000, 1, 0, 0, 1));
      end
      rst = 1'b0;
      step();
      chk("first_tie_cpu", ex(1, 16'h1234, 1, 1, 0, 0));
      drive(0, 16'h0000, 1, 0, 16'h0000, 1);
      step();
      chk("first_tie_done", ex(0, 16'h1234, 1, 0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].cr, vecs[i].ca, vecs[i].cw, vecs[i].dr, vecs[i].da, vecs[i].dw);
         step();
         chk($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Reset during the second bus_en cycle of a PIA access
      drive(1, 16'hD000, 1, 0, 16'h0000, 1);
      step();
      chk("abort_cyc1", ex(1, 16'hD000, 1, 0, 0, 0));
      step();
      chk("abort_cyc2", ex(1, 16'hD000, 1, 0, 0, 0));
      rst = 1'b1;
      #1;
      chk("abort_async", ex(0, 16'h0000, 1, 0, 0, 1));
      drive(0, 16'h0000, 1, 0, 16'h0000, 1);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("abort_hold", ex(0, 16'h0000, 1, 0, 0, 1));
      end
      rst = 1'b0;
      step();
      chk("abort_idle", ex(0, 16'h0000, 1, 0, 0, 1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
